// File: rtl/pixel_stream_frame_checker.sv
// pixel_stream_frame_checker
// Watches an AXI4-Stream video stream (tuser = start of frame, tlast = end of line)
// for framing errors against the configured active raster, while passing every
// beat through a one-entry register slice untouched. Reports sticky error flags,
// a completed-frame counter and a lock indication after an error-free frame.

module pixel_stream_frame_checker #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,

    input  logic                  clear_errors,
    output logic [15:0]           frame_count,
    output logic                  err_sof_missing,
    output logic                  err_sof_early,
    output logic                  err_eol_early,
    output logic                  err_eol_late,
    output logic                  locked
);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    // Index of the last pixel in a line, the saturation value of the pixel
    // counter, and the index of the last line in a frame.
    localparam logic [12:0] X_LAST = 13'(H_ACTIVE - 1);
    localparam logic [12:0] X_MAX  = 13'(H_ACTIVE);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);

    state_t                  r_state;
    logic [12:0]             r_xCnt;
    logic [11:0]             r_yCnt;
    logic                    r_frameClean;
    logic                    r_locked;
    logic [15:0]             r_frameCount;
    logic                    r_errSofMissing;
    logic                    r_errSofEarly;
    logic                    r_errEolEarly;
    logic                    r_errEolLate;

    logic [DATA_WIDTH-1:0]   r_mData;
    logic                    r_mValid;
    logic                    r_mUser;
    logic                    r_mLast;

    logic                    w_accept;
    logic                    w_setSofMissing;
    logic                    w_setSofEarly;
    logic                    w_setEolEarly;
    logic                    w_setEolLate;
    logic                    w_frameEnd;
    logic                    w_anyErr;

    // The slice can take a new beat whenever it is empty or its beat is leaving.
    assign s_axis_tready = !r_mValid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = r_mData;
    assign m_axis_tvalid = r_mValid;
    assign m_axis_tuser  = r_mUser;
    assign m_axis_tlast  = r_mLast;

    assign frame_count     = r_frameCount;
    assign locked          = r_locked;
    assign err_sof_missing = r_errSofMissing;
    assign err_sof_early   = r_errSofEarly;
    assign err_eol_early   = r_errEolEarly;
    assign err_eol_late    = r_errEolLate;

    // Register slice: capture accepted beats unchanged, drop valid once the beat is taken.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_mData  <= '0;
            r_mValid <= 1'b0;
            r_mUser  <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (w_accept) begin
            r_mData  <= s_axis_tdata;
            r_mValid <= 1'b1;
            r_mUser  <= s_axis_tuser;
            r_mLast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_mValid <= 1'b0;
        end
    end

    // Classify the accepted beat; a start-of-frame marker overrides any end-of-line on the same beat.
    always_comb begin
        w_setSofMissing = 1'b0;
        w_setSofEarly   = 1'b0;
        w_setEolEarly   = 1'b0;
        w_setEolLate    = 1'b0;
        w_frameEnd      = 1'b0;
        if (w_accept) begin
            if (r_state == WAIT_SOF) begin
                w_setSofMissing = !s_axis_tuser;
            end else if (s_axis_tuser) begin
                w_setSofEarly = 1'b1;
            end else if (s_axis_tlast) begin
                w_setEolEarly = (r_xCnt < X_LAST);
                w_frameEnd    = (r_yCnt == Y_LAST);
            end else begin
                w_setEolLate  = (r_xCnt == X_LAST);
            end
        end
    end

    assign w_anyErr = w_setSofMissing || w_setSofEarly || w_setEolEarly || w_setEolLate;

    // Framing FSM with pixel/line counters, frame counter, frame-clean tracking and lock.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= WAIT_SOF;
            r_xCnt       <= '0;
            r_yCnt       <= '0;
            r_frameClean <= 1'b0;
            r_locked     <= 1'b0;
            r_frameCount <= '0;
        end else if (w_accept) begin
            if (s_axis_tuser) begin
                r_state      <= ACTIVE;
                r_xCnt       <= 13'd1;
                r_yCnt       <= '0;
                r_frameClean <= 1'b1;
            end else if (r_state == ACTIVE) begin
                if (w_anyErr) begin
                    r_frameClean <= 1'b0;
                end
                if (s_axis_tlast) begin
                    r_xCnt <= '0;
                    if (w_frameEnd) begin
                        r_yCnt       <= '0;
                        r_state      <= WAIT_SOF;
                        r_frameCount <= r_frameCount + 16'd1;
                    end else begin
                        r_yCnt <= r_yCnt + 12'd1;
                    end
                end else if (r_xCnt != X_MAX) begin
                    r_xCnt <= r_xCnt + 13'd1;
                end
            end
            if (w_anyErr) begin
                r_locked <= 1'b0;
            end else if (w_frameEnd && r_frameClean) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Sticky error flags: a new error on the clearing cycle still wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_errSofMissing <= 1'b0;
            r_errSofEarly   <= 1'b0;
            r_errEolEarly   <= 1'b0;
            r_errEolLate    <= 1'b0;
        end else begin
            r_errSofMissing <= (r_errSofMissing && !clear_errors) || w_setSofMissing;
            r_errSofEarly   <= (r_errSofEarly   && !clear_errors) || w_setSofEarly;
            r_errEolEarly   <= (r_errEolEarly   && !clear_errors) || w_setEolEarly;
            r_errEolLate    <= (r_errEolLate    && !clear_errors) || w_setEolLate;
        end
    end

endmodule

// File: tb/tb_pixel_stream_frame_checker.sv
// tb_pixel_stream_frame_checker
// Drives framed and randomly corrupted video beats into the checker with a
// reference model of the framing rules. Output beats and the status snapshot
// taken when each beat was accepted are queued and compared by a monitor when
// the beat appears on the output side.

module tb_pixel_stream_frame_checker;

    localparam int DW = 24;
    localparam int H  = 4;
    localparam int V  = 3;

    typedef struct packed {
        logic [15:0] fc;
        logic        lk;
        logic [3:0]  fl;
    } status_t;

    typedef logic [DW+1:0] beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] sTdata = '0;
    logic          sTvalid = 1'b0;
    logic          sTready;
    logic          sTuser = 1'b0;
    logic          sTlast = 1'b0;
    logic [DW-1:0] mTdata;
    logic          mTvalid;
    logic          mTready = 1'b1;
    logic          mTuser;
    logic          mTlast;
    logic          clearErrors = 1'b0;
    logic [15:0]   frameCount;
    logic          errSofMissing;
    logic          errSofEarly;
    logic          errEolEarly;
    logic          errEolLate;
    logic          lockedOut;

    int checks = 0;
    int errors = 0;
    int readyMode = 0;

    beat_t   dataQ[$];
    status_t statusQ[$];

    bit       mInFrame = 0;
    int       mPix = 0;
    int       mLine = 0;
    int       mFrames = 0;
    bit       mClean = 0;
    bit       mLocked = 0;
    bit [3:0] mFlags = '0;

    pixel_stream_frame_checker #(
        .DATA_WIDTH(DW),
        .H_ACTIVE  (H),
        .V_ACTIVE  (V)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .s_axis_tdata   (sTdata),
        .s_axis_tvalid  (sTvalid),
        .s_axis_tready  (sTready),
        .s_axis_tuser   (sTuser),
        .s_axis_tlast   (sTlast),
        .m_axis_tdata   (mTdata),
        .m_axis_tvalid  (mTvalid),
        .m_axis_tready  (mTready),
        .m_axis_tuser   (mTuser),
        .m_axis_tlast   (mTlast),
        .clear_errors   (clearErrors),
        .frame_count    (frameCount),
        .err_sof_missing(errSofMissing),
        .err_sof_early  (errSofEarly),
        .err_eol_early  (errEolEarly),
        .err_eol_late   (errEolLate),
        .locked         (lockedOut)
    );

    // Free-running clock.
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic status_t modelStatus();
        status_t s;
        s.fc = 16'(mFrames);
        s.lk = mLocked;
        s.fl = mFlags;
        return s;
    endfunction

    function automatic status_t dutStatus();
        status_t s;
        s.fc = frameCount;
        s.lk = lockedOut;
        s.fl = {errSofMissing, errSofEarly, errEolEarly, errEolLate};
        return s;
    endfunction

    task automatic modelReset();
        mInFrame = 0;
        mPix = 0;
        mLine = 0;
        mFrames = 0;
        mClean = 0;
        mLocked = 0;
        mFlags = '0;
    endtask

    // Flag bits: [3] sof missing, [2] sof early, [1] eol early, [0] eol late.
    task automatic modelBeat(input bit u, input bit l, input bit clr);
        bit [3:0] setFlags;
        setFlags = '0;
        if (u) begin
            if (mInFrame) setFlags[2] = 1'b1;
            mInFrame = 1;
            mPix = 1;
            mLine = 0;
            mClean = 1;
        end else if (!mInFrame) begin
            setFlags[3] = 1'b1;
        end else if (!l) begin
            if (mPix == H - 1) setFlags[0] = 1'b1;
            if (mPix < H) mPix++;
            if (setFlags != 0) mClean = 0;
        end else begin
            if (mPix < H - 1) setFlags[1] = 1'b1;
            if (setFlags != 0) mClean = 0;
            mPix = 0;
            if (mLine == V - 1) begin
                mLine = 0;
                mInFrame = 0;
                mFrames = (mFrames + 1) % 65536;
                if (mClean) mLocked = 1;
            end else begin
                mLine++;
            end
        end
        if (setFlags != 0) mLocked = 0;
        mFlags = (mFlags & ~{4{clr}}) | setFlags;
    endtask

    task automatic checkStatus(input string name);
        checkOutput(name, 64'(dutStatus()), 64'(modelStatus()));
    endtask

    // Offer one beat until it is accepted; the optional clear pulse lasts only its first cycle.
    task automatic applyStimulus(input logic [DW-1:0] d, input bit u, input bit l, input bit clr);
        int  waitCycles;
        bit  done;
        waitCycles = 0;
        done = 0;
        sTdata = d;
        sTuser = u;
        sTlast = l;
        sTvalid = 1'b1;
        clearErrors = clr;
        while (!done) begin
            @(negedge ACLK);
            if (sTready) begin
                done = 1;
                dataQ.push_back({d, u, l});
                modelBeat(u, l, clearErrors);
                statusQ.push_back(modelStatus());
            end else begin
                if (clearErrors) mFlags = '0;
                waitCycles++;
                if (waitCycles > 200) begin
                    checkOutput("acceptTimeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
            @(posedge ACLK);
            #1;
            clearErrors = 1'b0;
        end
        sTvalid = 1'b0;
        sTuser = 1'b0;
        sTlast = 1'b0;
    endtask

    task automatic pulseClear();
        clearErrors = 1'b1;
        @(negedge ACLK);
        mFlags = '0;
        @(posedge ACLK);
        #1;
        clearErrors = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic sendCleanFrame();
        for (int l = 0; l < V; l++)
            for (int p = 0; p < H; p++)
                applyStimulus(DW'($urandom), (l == 0 && p == 0), (p == H - 1), 1'b0);
    endtask

    // Output-side ready: always high, random, or held low.
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (readyMode)
                0:       mTready = 1'b1;
                1:       mTready = 1'($urandom_range(0, 1));
                default: mTready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each beat on first presentation, then verify it holds while stalled.
    initial begin
        bit      newBeat;
        beat_t   expBeat;
        status_t expSt;
        newBeat = 1;
        expBeat = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                newBeat = 1;
            end else begin
                if (mTvalid) begin
                    if (newBeat) begin
                        if (dataQ.size() == 0) begin
                            checkOutput("unexpectedBeat", 64'd1, 64'd0);
                        end else begin
                            expBeat = dataQ.pop_front();
                            expSt = statusQ.pop_front();
                            checkOutput("beatData", 64'({mTdata, mTuser, mTlast}), 64'(expBeat));
                            checkOutput("beatStatus", 64'(dutStatus()), 64'(expSt));
                        end
                    end else begin
                        checkOutput("stallHold", 64'({mTdata, mTuser, mTlast}), 64'(expBeat));
                    end
                end
                newBeat = !mTvalid || mTready;
            end
        end
    end

    initial begin
        int genPix;
        int genLine;
        int fcBefore;

        // Reset state
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("resetValid", 64'(mTvalid), 64'd0);
        checkOutput("resetStatus", 64'(dutStatus()), 64'd0);
        ARESETN = 1'b1;
        #1;
        checkOutput("resetReady", 64'(sTready), 64'd1);
        idleCycles(2);

        // Two clean frames, output always ready
        readyMode = 0;
        sendCleanFrame();
        sendCleanFrame();
        checkOutput("cleanFrames", 64'(frameCount), 64'd2);
        checkOutput("cleanLocked", 64'(lockedOut), 64'd1);
        checkStatus("cleanStatus");

        // Early end of line on line 1
        for (int l = 0; l < V; l++) begin
            int len;
            len = (l == 1) ? 3 : H;
            for (int p = 0; p < len; p++)
                applyStimulus(DW'($urandom), (l == 0 && p == 0), (p == len - 1), 1'b0);
        end
        checkOutput("eolEarlyFlag", 64'(errEolEarly), 64'd1);
        checkOutput("eolEarlyLocked", 64'(lockedOut), 64'd0);
        checkOutput("eolEarlyFrames", 64'(frameCount), 64'd3);
        pulseClear();
        checkOutput("eolEarlyCleared", 64'(errEolEarly), 64'd0);
        checkStatus("afterClear");

        // Overlong line 0 (6 beats)
        for (int p = 0; p < 6; p++) begin
            applyStimulus(DW'($urandom), (p == 0), (p == 5), 1'b0);
            if (p == 2) checkOutput("eolLateNotYet", 64'(errEolLate), 64'd0);
            if (p == 3) checkOutput("eolLateFlag", 64'(errEolLate), 64'd1);
        end
        for (int l = 1; l < V; l++)
            for (int p = 0; p < H; p++)
                applyStimulus(DW'($urandom), 1'b0, (p == H - 1), 1'b0);
        checkOutput("eolLateNextLine", 64'(errEolEarly), 64'd0);
        checkStatus("eolLateStatus");

        // Missing start of frame
        pulseClear();
        fcBefore = mFrames;
        for (int i = 0; i < 3; i++) applyStimulus(DW'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("sofMissingFlag", 64'(errSofMissing), 64'd1);
        checkOutput("sofMissingLocked", 64'(lockedOut), 64'd0);
        sendCleanFrame();
        checkOutput("sofMissingFrames", 64'(frameCount), 64'(fcBefore + 1));
        sendCleanFrame();
        checkOutput("relockAfterClean", 64'(lockedOut), 64'd1);

        // Start of frame arriving at beat 6, clear on the same beat as the error
        pulseClear();
        fcBefore = mFrames;
        for (int b = 0; b < 6; b++) applyStimulus(DW'($urandom), (b == 0), ((b % H) == H - 1), 1'b0);
        applyStimulus(DW'($urandom), 1'b1, 1'b0, 1'b1);
        checkOutput("sofEarlyFlag", 64'(errSofEarly), 64'd1);
        checkOutput("sofEarlyFrames", 64'(frameCount), 64'(fcBefore));
        for (int b = 1; b < H * V; b++) applyStimulus(DW'($urandom), 1'b0, ((b % H) == H - 1), 1'b0);
        checkOutput("sofEarlyRestart", 64'(frameCount), 64'(fcBefore + 1));
        checkStatus("sofEarlyStatus");

        // Random stream with occasional corruption and output stalls
        readyMode = 1;
        genPix = 0;
        genLine = 0;
        for (int i = 0; i < 400; i++) begin
            bit u;
            bit l;
            u = (genPix == 0 && genLine == 0) ^ ($urandom_range(0, 19) == 0);
            l = (genPix == H - 1) ^ ($urandom_range(0, 19) == 0);
            applyStimulus(DW'($urandom), u, l, ($urandom_range(0, 15) == 0));
            genPix++;
            if (genPix == H) begin
                genPix = 0;
                genLine = (genLine + 1) % V;
            end
            if ($urandom_range(0, 7) == 0) idleCycles($urandom_range(1, 3));
        end
        readyMode = 0;
        idleCycles(3);
        checkStatus("randomStatus");

        // Reset in the middle of a frame with a beat held in the slice
        for (int b = 0; b < 5; b++) applyStimulus(DW'($urandom), (b == 0), ((b % H) == H - 1), 1'b0);
        readyMode = 2;
        applyStimulus(DW'($urandom), 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("heldBeatValid", 64'(mTvalid), 64'd1);
        #2;
        ARESETN = 1'b0;
        dataQ.delete();
        statusQ.delete();
        modelReset();
        #1;
        checkOutput("midResetValid", 64'(mTvalid), 64'd0);
        checkOutput("midResetFields", 64'({mTdata, mTuser, mTlast}), 64'd0);
        checkOutput("midResetStatus", 64'(dutStatus()), 64'd0);
        checkOutput("midResetReady", 64'(sTready), 64'd1);
        readyMode = 1;
        idleCycles(2);
        ARESETN = 1'b1;
        idleCycles(1);
        sendCleanFrame();
        readyMode = 0;
        idleCycles(3);
        checkOutput("postResetFrames", 64'(frameCount), 64'd1);
        checkOutput("postResetLocked", 64'(lockedOut), 64'd1);
        checkOutput("dataQueueDrained", 64'(dataQ.size()), 64'd0);
        checkOutput("statusQueueDrained", 64'(statusQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
